// File: rtl/spi_xact_ctrl.sv
// SPI slave transaction controller: turns 2-byte SPI frames into
// register-file reads/writes, with abort, timeout and error tracking.
module spi_xact_ctrl #(
  parameter int TIMEOUT = 4096,
  parameter int CNTW    = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ss,
  input  logic       rxvalid,
  input  logic [7:0] rxbyte,
  input  logic [7:0] regrdata,
  input  logic       errclr,
  output logic       txload,
  output logic [7:0] txbyte,
  output logic [6:0] regaddr,
  output logic [7:0] regwdata,
  output logic       regwe,
  output logic       regre,
  output logic       busy,
  output logic       err,
  output logic [7:0] xactcnt
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic            ss_q;
  logic            rw_q;
  logic [CNTW-1:0] cnt;
  logic            start_ld;
  logic            rd_load;
  logic [7:0]      txbyte_q;

  logic ss_rise;
  logic cnt_hit;
  logic in_frame;
  logic start;
  logic ld_addr;
  logic wr_go;
  logic rd_go;
  logic xact_inc;
  logic set_err;

  assign ss_rise  = ss & ~ss_q;
  assign cnt_hit  = (cnt == CNTW'(TIMEOUT - 1));
  assign in_frame = (state == ADDR) || (state == DATA);

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    ld_addr  = 1'b0;
    wr_go    = 1'b0;
    rd_go    = 1'b0;
    xact_inc = 1'b0;
    set_err  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss_rise) begin
          state_nx = ADDR;
          start    = 1'b1;
        end
      end
      ADDR: begin
        if (rxvalid) begin
          ld_addr = 1'b1;
          if (ss) begin
            state_nx = DATA;
            rd_go    = rxbyte[7];
          end else begin
            state_nx = IDLE;
            set_err  = 1'b1;
          end
        end else if (!ss) begin
          state_nx = IDLE;
          set_err  = 1'b1;
        end else if (cnt_hit) begin
          state_nx = DONE;
          set_err  = 1'b1;
        end
      end
      DATA: begin
        if (rxvalid) begin
          xact_inc = 1'b1;
          wr_go    = ~rw_q;
          state_nx = ss ? DONE : IDLE;
        end else if (!ss) begin
          state_nx = IDLE;
          set_err  = 1'b1;
        end else if (cnt_hit) begin
          state_nx = DONE;
          set_err  = 1'b1;
        end
      end
      DONE: begin
        if (rxvalid) set_err = 1'b1;
        if (!ss) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ss history resets high so a select held across reset is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ss_q  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ss_q  <= ss;
      if (start || rxvalid || !in_frame) cnt <= '0;
      else cnt <= cnt + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q     <= 1'b0;
      regaddr  <= '0;
      regwdata <= '0;
      regwe    <= 1'b0;
      regre    <= 1'b0;
      start_ld <= 1'b0;
      rd_load  <= 1'b0;
      txbyte_q <= '0;
      err      <= 1'b0;
      xactcnt  <= '0;
    end else begin
      if (ld_addr) begin
        regaddr <= rxbyte[6:0];
        rw_q    <= rxbyte[7];
      end
      if (wr_go) regwdata <= rxbyte;
      regwe    <= wr_go;
      regre    <= rd_go;
      start_ld <= start;
      rd_load  <= regre && (state_nx != IDLE);
      if (start) txbyte_q <= '0;
      else if (rd_load) txbyte_q <= regrdata;
      if (set_err) err <= 1'b1;
      else if (errclr) err <= 1'b0;
      xactcnt <= xactcnt + 8'(xact_inc);
    end
  end

  // read data is forwarded in its arrival cycle so the load sees it at once
  assign txload = start_ld | rd_load;
  assign txbyte = rd_load ? regrdata : txbyte_q;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_spi_xact_ctrl.sv
// Scoreboard bench for spi_xact_ctrl: queued expectations checked
// by a negedge monitor against a frame-level reference model.
module tb_spi_xact_ctrl;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       ss;
  logic       rxvalid;
  logic [7:0] rxbyte;
  logic [7:0] regrdata = 8'h00;
  logic       errclr;
  logic       txload;
  logic [7:0] txbyte;
  logic [6:0] regaddr;
  logic [7:0] regwdata;
  logic       regwe;
  logic       regre;
  logic       busy;
  logic       err;
  logic [7:0] xactcnt;

  spi_xact_ctrl #(.TIMEOUT(TMO), .CNTW(5)) dut (
    .clk(clk), .reset(reset), .ss(ss), .rxvalid(rxvalid),
    .rxbyte(rxbyte), .regrdata(regrdata), .errclr(errclr),
    .txload(txload), .txbyte(txbyte), .regaddr(regaddr),
    .regwdata(regwdata), .regwe(regwe), .regre(regre),
    .busy(busy), .err(err), .xactcnt(xactcnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;

  logic [7:0]  ref_mem [128] = '{default: 8'h00};
  logic [7:0]  rf      [128] = '{default: 8'h00};
  logic [7:0]  exp_tx [$];
  logic [6:0]  exp_rd [$];
  logic [14:0] exp_wr [$];
  logic [7:0]  exp_xact = 8'h00;
  logic        exp_err  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected pulse", name);
  endtask

  // register file the controller talks to
  always @(posedge clk) begin
    if (regwe) rf[regaddr] <= regwdata;
    if (regre) regrdata <= rf[regaddr];
  end

  logic prev_we = 1'b0;
  logic prev_re = 1'b0;
  logic prev_tl = 1'b0;

  always @(negedge clk) begin
    logic [14:0] w;
    logic [6:0]  r;
    logic [7:0]  t;
    if (reset) begin
      prev_we = 1'b0;
      prev_re = 1'b0;
      prev_tl = 1'b0;
    end else begin
      if (regwe) begin
        wr_pulses++;
        if (exp_wr.size() == 0) flag("regwe");
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", regaddr, w[14:8]);
          chk("wr_data", regwdata, w[7:0]);
        end
      end
      if (regre) begin
        if (exp_rd.size() == 0) flag("regre");
        else begin
          r = exp_rd.pop_front();
          chk("rd_addr", regaddr, r);
        end
      end
      if (txload) begin
        if (exp_tx.size() == 0) flag("txload");
        else begin
          t = exp_tx.pop_front();
          chk("txbyte", txbyte, t);
        end
      end
      if (regwe && regre) flag("regwe_with_regre");
      if (regwe && prev_we) flag("regwe_2cyc");
      if (regre && prev_re) flag("regre_2cyc");
      if (txload && prev_tl) flag("txload_2cyc");
      prev_we = regwe;
      prev_re = regre;
      prev_tl = txload;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxvalid = 1'b1;
    rxbyte  = b;
    tick(1);
    rxvalid = 1'b0;
  endtask

  task automatic frame(input bit rw, input logic [6:0] a,
                       input logic [7:0] d, input int g1,
                       input int g2, input bit extra);
    tick(1);
    ss = 1'b1;
    exp_tx.push_back(8'h00);
    tick(1 + g1);
    send_byte({rw, a});
    if (rw) begin
      exp_rd.push_back(a);
      exp_tx.push_back(ref_mem[a]);
      @(negedge clk);
      chk("regre_at_n1", regre, 1'b1);
      @(negedge clk);
      chk("txload_at_n2", txload, 1'b1);
      tick(1);
    end
    tick(g2);
    send_byte(d);
    exp_xact++;
    if (!rw) begin
      exp_wr.push_back({a, d});
      ref_mem[a] = d;
      @(negedge clk);
      chk("regwe_at_n1", regwe, 1'b1);
      tick(1);
    end
    if (extra) begin
      send_byte($urandom_range(0, 255));
      exp_err = 1'b1;
    end
    ss = 1'b0;
    tick(2);
    chk("busy_end", busy, 1'b0);
    chk("xactcnt", xactcnt, exp_xact);
    chk("err", err, exp_err);
  endtask

  task automatic clear_err();
    errclr = 1'b1;
    tick(1);
    errclr = 1'b0;
    exp_err = 1'b0;
    chk("errclr", err, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_txload"}, txload, 1'b0);
    chk({tag, "_txbyte"}, txbyte, 8'h00);
    chk({tag, "_regaddr"}, regaddr, 7'h00);
    chk({tag, "_regwdata"}, regwdata, 8'h00);
    chk({tag, "_regwe"}, regwe, 1'b0);
    chk({tag, "_regre"}, regre, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_xactcnt"}, xactcnt, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1;
    ss = 1'b0;
    rxvalid = 1'b0;
    rxbyte = 8'h00;
    errclr = 1'b0;
    #1;
    chk_zero("rst");
    tick(3);
    reset = 1'b0;
    tick(2);

    frame(1'b0, 7'h55, 8'hAA, 1, 1, 1'b0);
    chk("w55_addr", regaddr, 7'h55);
    chk("w55_data", regwdata, 8'hAA);

    frame(1'b0, 7'h00, 8'h3C, 0, 0, 1'b0);
    frame(1'b1, 7'h00, 8'h00, 1, 0, 1'b0);

    tick(1);
    ss = 1'b1;
    exp_tx.push_back(8'h00);
    tick(2);
    send_byte(8'h12);
    ss = 1'b0;
    exp_err = 1'b1;
    tick(2);
    chk("abort_busy", busy, 1'b0);
    chk("abort_err", err, 1'b1);
    chk("abort_xact", xactcnt, exp_xact);
    clear_err();

    tick(1);
    ss = 1'b1;
    exp_tx.push_back(8'h00);
    tick(1 + TMO - 1);
    chk("tmo_early_err", err, 1'b0);
    tick(1);
    chk("tmo_err", err, 1'b1);
    chk("tmo_busy", busy, 1'b1);
    tick(3);
    chk("tmo_hold", busy, 1'b1);
    ss = 1'b0;
    tick(2);
    chk("tmo_idle", busy, 1'b0);
    chk("tmo_xact", xactcnt, exp_xact);
    exp_err = 1'b1;
    clear_err();

    for (int i = 0; i < 150; i++) begin
      bit x;
      x = ($urandom_range(0, 9) == 0);
      frame($urandom_range(0, 1), $urandom_range(0, 127),
            $urandom_range(0, 255), $urandom_range(0, 3),
            $urandom_range(0, 3), x);
      if (x) clear_err();
    end

    tick(1);
    ss = 1'b1;
    exp_tx.push_back(8'h00);
    tick(2);
    send_byte(8'h21);
    tick(1);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("midrst");
    exp_xact = 8'h00;
    exp_err = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
    send_byte(8'h77);
    tick(3);
    chk("postrst_busy", busy, 1'b0);
    ss = 1'b0;
    tick(2);
    frame(1'b0, 7'h21, 8'h99, 0, 0, 1'b1);
    clear_err();

    base = wr_pulses;
    for (int i = 0; i < 256; i++)
      frame(1'b0, 7'(i), 8'(i ^ 8'h5A), 0, 0, 1'b0);
    chk("wrap_pulses", wr_pulses - base, 256);
    chk("wrap_xact", xactcnt, 8'h01);

    tick(4);
    chk("q_wr_empty", exp_wr.size(), 0);
    chk("q_rd_empty", exp_rd.size(), 0);
    chk("q_tx_empty", exp_tx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xact_ctrl.md
SPI_XACT_CTRL -- requirements
Module: spi_xact_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 4096, clk cycles allowed with no completed byte while selected before abort.
REQ-002 Parameter: CNTW, 13, width of the timeout counter (2^CNTW > TIMEOUT).
REQ-003 Port: clk  in  1  system clock; all logic on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: ss  in  1  slave select, already synchronized to clk, active-high (1 = selected).
REQ-006 Port: rxvalid  in  1  one-clk strobe; SPI shifter completed a byte.
REQ-007 Port: rxbyte  in  8  received byte; valid when rxvalid=1.
REQ-008 Port: regrdata  in  8  register-file read data; valid the cycle after regre.
REQ-009 Port: errclr  in  1  one-clk strobe; clears err.
REQ-010 Port: txload  out  1  one-clk strobe; SPI shifter loads txbyte.
REQ-011 Port: txbyte  out  8  byte to shift out on miso.
REQ-012 Port: regaddr  out  7  register address.
REQ-013 Port: regwdata  out  8  register write data.
REQ-014 Port: regwe  out  1  one-clk register write strobe.
REQ-015 Port: regre  out  1  one-clk register read strobe.
REQ-016 Port: busy  out  1  1 when state != IDLE.
REQ-017 Port: err  out  1  sticky protocol error flag.
REQ-018 Port: xactcnt  out  8  count of completed transactions, wraps 0xFF->0x00.

Function
REQ-019 Frame = 2 bytes: byte0 = {rw, addr[6:0]} (rw=1 read), byte1 = write data (write) or don't-care (read).
REQ-020 States: IDLE, ADDR, DATA, DONE; registered, one-hot or binary at implementer's choice.
REQ-021 IDLE -> ADDR on ss 0->1 (ss=1 while previous sample 0); same cycle txload=1, txbyte=0x00.
REQ-022 ADDR, rxvalid=1: regaddr<=rxbyte[6:0], rw latched, -> DATA.
REQ-023 Read: regre=1 exactly 1 cycle after address rxvalid; txbyte<=regrdata and txload=1 exactly 2 cycles after address rxvalid.
REQ-024 DATA, rxvalid=1, write: regwdata<=rxbyte, regwe=1 the next cycle; -> DONE.
REQ-025 DATA, rxvalid=1, read: byte discarded, no regwe; -> DONE.
REQ-026 Entry to DONE from DATA increments xactcnt by 1 (modulo 256).
REQ-027 DONE: rxvalid ignored except err<=1; stays in DONE until ss=0, then -> IDLE.
REQ-028 ss=0 in ADDR or DATA without same-cycle rxvalid: abort, no regwe, err<=1, -> IDLE.
REQ-029 ss=0 and rxvalid=1 same cycle: byte processed per REQ-022/024/025 first, then -> IDLE; a completed write still issues regwe; address-only aborts set err.
REQ-030 Timeout counter clears on ss rise and each rxvalid, increments in ADDR/DATA; reaching TIMEOUT: err<=1, -> DONE without regwe or xactcnt increment.
REQ-031 err set has priority over errclr in same cycle.
REQ-032 regwe, regre, txload never asserted for more than 1 consecutive cycle; regwe and regre never asserted together.
REQ-033 ss held 1 from reset release is not an edge; block stays IDLE until ss seen 0 then 1.

Reset
REQ-034 reset=1 forces asynchronously: state IDLE, txload/regwe/regre/busy/err=0, txbyte/regwdata/xactcnt=0x00, regaddr=0, timeout counter 0, ss history 0... treated as 1 per REQ-033.
REQ-035 Reset asserted mid-transaction discards it: no regwe/regre/txload afterwards until a new ss rise.

Verification
REQ-036 ss rise, rxbyte 0x55 then 0xAA -> regwe 1 cycle after second rxvalid, regaddr=0x55, regwdata=0xAA, xactcnt 0->1, err=0.
REQ-037 ss rise, rxbyte 0x80, regrdata=0x3C -> regre at N+1 with regaddr=0x00, txload at N+2 with txbyte=0x3C; second byte 0x00 -> no regwe, xactcnt +1.
REQ-038 ss rise, byte 0x12, ss falls -> no regwe, err=1, busy=0; errclr -> err=0.
REQ-039 TIMEOUT=16, ss rise, no rxvalid for 16 clks -> err=1, state DONE, busy=1 until ss=0.
REQ-040 Reset asserted in DATA of a write -> outputs zero immediately, no regwe after release; third byte in DONE -> err=1.
REQ-041 256 back-to-back write frames -> xactcnt wraps to 0x00, 256 regwe pulses.
